spi_regfile_peripheral: RTL and testbench

//  SPI mode-0 target giving the host read/write access to a parametrised bank of control registers.
//  - Frame: 1 R/W bit, ADDR_W address bits, DATA_W data bits, all MSB first.
//  - Writes drive the flat register bus into the PWM/output-enable logic.
//  - Reads return a register on cipo.
//  - Adds to the previous peripheral: read-back, a write strobe, generic width/depth and abort on early nCS.

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_regfile_peripheral_if.sv | 11 +
 rtl/spi_sync_edge.sv | 24 ++
 rtl/spi_regfile_peripheral.sv | 129 ++++++++++++
 tb/tb_spi_regfile_peripheral.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-file target: FSM encoding,
// R/W bit values and frame length helper.
package spi_pkg;
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} spi_state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  function automatic int frame_bits(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction
endpackage

// File: rtl/spi_regfile_peripheral_if.sv
// SPI pin bundle; the host side drives nCS/SCLK/copi, the target drives cipo/cipo_oe.
interface spi_regfile_peripheral_if;
  logic nCS;
  logic SCLK;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (output nCS, SCLK, copi, input cipo, cipo_oe);
  modport slave  (input nCS, SCLK, copi, output cipo, cipo_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an async input, with rise/fall pulses taken
// from the last two synchronised samples.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  // sh[STAGES-1] is the synchronised value, sh[STAGES] its previous sample
  logic [STAGES:0] sh;

  always_ff @(posedge clk or posedge rst)
    if (rst) sh <= {(STAGES+1){RST_VAL}};
    else     sh <= {sh[STAGES-1:0], d};

  assign q    = sh[STAGES-1];
  assign rise =  sh[STAGES-1] & ~sh[STAGES];
  assign fall = ~sh[STAGES-1] &  sh[STAGES];
endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 target with read/write access to NUM_REGS registers of DATA_W bits.
// Frame: rw, addr[ADDR_W], data[DATA_W], MSB first; commits on frame completion.
module spi_regfile_peripheral
  import spi_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_regfile_peripheral_if.slave    spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_q,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       busy
);
  localparam int FRAME    = frame_bits(ADDR_W, DATA_W);
  localparam int CMD_BITS = 1 + ADDR_W;
  localparam int CNT_W    = $clog2(FRAME + 1);

  logic ncs_q, ncs_rise, ncs_fall;
  logic sclk_rise, sclk_fall, sclk_unused;
  logic copi_q;
  logic [1:0] copi_edge_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
    .clk(clk), .rst(rst), .d(spi.nCS), .q(ncs_q), .rise(ncs_rise), .fall(ncs_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d(spi.SCLK), .q(sclk_unused), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
    .clk(clk), .rst(rst), .d(spi.copi), .q(copi_q),
    .rise(copi_edge_unused[0]), .fall(copi_edge_unused[1]));

  spi_state_e          state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   cmd_sh, addr;
  logic [ADDR_W:0]     cmd_nxt;
  logic [DATA_W-1:0]   data_sh, tx, rd_word;
  logic                rw, in_range, cmd_in_range, committed, cipo_oe;
  logic                cmd_last, data_last, abort, commit;

  assign cmd_nxt      = {cmd_sh, copi_q};
  assign cmd_in_range = ({1'b0, cmd_nxt[ADDR_W-1:0]} < (ADDR_W+1)'(NUM_REGS));
  assign commit       = (state == DONE) && !committed && (rw == RW_WRITE) && in_range;
  assign spi.cipo_oe  = cipo_oe;
  assign spi.cipo     = cipo_oe & tx[DATA_W-1];

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  // Abort beats the last command bit, but the last data bit beats abort so
  // a frame whose final rise coincides with nCS rise still commits.
  always_comb begin
    state_nxt = state;
    cmd_last  = 1'b0;
    data_last = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: if (ncs_fall) state_nxt = CMD;
      CMD: begin
        if (ncs_rise) begin
          abort = 1'b1; state_nxt = IDLE;
        end else if (sclk_rise && cnt == CNT_W'(CMD_BITS-1)) begin
          cmd_last = 1'b1; state_nxt = DATA;
        end
      end
      DATA: begin
        if (sclk_rise && cnt == CNT_W'(FRAME-1)) begin
          data_last = 1'b1; state_nxt = DONE;
        end else if (ncs_rise) begin
          abort = 1'b1; state_nxt = IDLE;
        end
      end
      DONE: if (ncs_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (cmd_nxt[ADDR_W-1:0] == ADDR_W'(k)) rd_word = regs_q[k*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0; cmd_sh <= '0; data_sh <= '0; tx <= '0; addr <= '0;
      rw <= RW_READ; in_range <= 1'b0; committed <= 1'b0; cipo_oe <= 1'b0;
      wr_strobe <= 1'b0; wr_addr <= '0; busy <= 1'b0;
    end else begin
      wr_strobe <= commit;
      if (commit) wr_addr <= addr;
      if (state == DONE) committed <= 1'b1;
      if (state == DONE && ncs_q) busy <= 1'b0;
      if (state == IDLE && ncs_fall) begin
        cnt <= '0; cmd_sh <= '0; data_sh <= '0; tx <= '0;
        committed <= 1'b0; busy <= 1'b1;
      end
      if ((state == CMD || state == DATA) && sclk_rise && !abort && cnt != CNT_W'(FRAME))
        cnt <= cnt + 1'b1;
      if (state == CMD && sclk_rise && !abort) cmd_sh <= cmd_nxt[ADDR_W-1:0];
      if (cmd_last) begin
        rw       <= cmd_nxt[ADDR_W];
        addr     <= cmd_nxt[ADDR_W-1:0];
        in_range <= cmd_in_range;
        if (cmd_nxt[ADDR_W] == RW_READ) begin
          tx <= rd_word; cipo_oe <= 1'b1;
        end
      end
      if (state == DATA && sclk_rise && !abort) data_sh <= {data_sh[DATA_W-2:0], copi_q};
      // first data-phase fall has no preceding data rise: keep the MSB on cipo
      if (state == DATA && sclk_fall && cnt > CNT_W'(CMD_BITS)) tx <= {tx[DATA_W-2:0], 1'b0};
      if (data_last) cipo_oe <= 1'b0;
      if (abort) begin
        tx <= '0; cipo_oe <= 1'b0; busy <= 1'b0;
      end
    end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    logic [DATA_W-1:0] q;
    always_ff @(posedge clk or posedge rst)
      if (rst)                              q <= '0;
      else if (commit && addr == ADDR_W'(k)) q <= data_sh;
    assign regs_q[k*DATA_W +: DATA_W] = q;
  end
endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench: default-parameter target plus a wide 4/16/12 instance,
// sharing one SPI driver selected by 'sel'.
module tb_spi_regfile_peripheral;
  localparam int HALF = 25;  // 1 MHz SCLK at 50 MHz clk

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic ncs_drv = 1'b1, sclk_drv = 1'b0, copi_drv = 1'b0;
  int   sel = 0;

  spi_regfile_peripheral_if sif1();
  spi_regfile_peripheral_if sif2();
  assign sif1.nCS  = (sel == 0) ? ncs_drv  : 1'b1;
  assign sif1.SCLK = (sel == 0) ? sclk_drv : 1'b0;
  assign sif1.copi = copi_drv;
  assign sif2.nCS  = (sel == 1) ? ncs_drv  : 1'b1;
  assign sif2.SCLK = (sel == 1) ? sclk_drv : 1'b0;
  assign sif2.copi = copi_drv;

  logic [39:0]  regs1; logic stb1; logic [6:0] wa1; logic busy1;
  logic [191:0] regs2; logic stb2; logic [3:0] wa2; logic busy2;

  spi_regfile_peripheral u_dut1 (
    .clk(clk), .rst(rst), .spi(sif1), .regs_q(regs1),
    .wr_strobe(stb1), .wr_addr(wa1), .busy(busy1));

  spi_regfile_peripheral #(.ADDR_W(4), .DATA_W(16), .NUM_REGS(12), .SYNC_STAGES(2)) u_dut2 (
    .clk(clk), .rst(rst), .spi(sif2), .regs_q(regs2),
    .wr_strobe(stb2), .wr_addr(wa2), .busy(busy2));

  // strobe-high clock counts; a two-clk strobe shows up as 2
  int stb_cnt1 = 0, stb_cnt2 = 0;
  always @(negedge clk) begin
    if (stb1) stb_cnt1 <= stb_cnt1 + 1;
    if (stb2) stb_cnt2 <= stb_cnt2 + 1;
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends 'send' of the nbits frame bits, then 'extra' SCLK pulses, then
  // raises nCS unless keep_low. cipo/cipo_oe sampled just before each rise.
  task automatic frame(input int s, input logic [31:0] bits, input int nbits, input int send,
                       input int extra, input bit keep_low,
                       output logic [31:0] rx, output logic [31:0] oe);
    sel = s; rx = '0; oe = '0;
    ncs_drv = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < send; i++) begin
      copi_drv = bits[nbits-1-i];
      wait_clk(HALF);
      rx = {rx[30:0], (s == 0) ? sif1.cipo    : sif2.cipo};
      oe = {oe[30:0], (s == 0) ? sif1.cipo_oe : sif2.cipo_oe};
      sclk_drv = 1'b1;
      wait_clk(HALF);
      sclk_drv = 1'b0;
    end
    for (int i = 0; i < extra; i++) begin
      wait_clk(HALF); sclk_drv = 1'b1;
      wait_clk(HALF); sclk_drv = 1'b0;
    end
    if (!keep_low) begin
      wait_clk(HALF);
      ncs_drv = 1'b1;
      wait_clk(2*HALF);
    end
  endtask

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  data;
    int          stb;
    logic [6:0]  wa;
    logic [39:0] regs;
    logic [7:0]  rd;
  } vec_t;

  vec_t tbl[7];
  logic [31:0] rx, oe;
  int s0;

  initial begin
    tbl[0] = '{1'b1, 7'd4, 8'h80, 1, 7'd4, 40'h80_00_00_00_00, 8'h00};
    tbl[1] = '{1'b1, 7'd2, 8'hA5, 1, 7'd2, 40'h80_00_A5_00_00, 8'h00};
    tbl[2] = '{1'b0, 7'd2, 8'h00, 0, 7'd2, 40'h80_00_A5_00_00, 8'hA5};
    tbl[3] = '{1'b1, 7'd9, 8'hFF, 0, 7'd2, 40'h80_00_A5_00_00, 8'h00};
    tbl[4] = '{1'b0, 7'd9, 8'h5C, 0, 7'd2, 40'h80_00_A5_00_00, 8'h00};
    tbl[5] = '{1'b1, 7'd0, 8'h11, 1, 7'd0, 40'h80_00_A5_00_11, 8'h00};
    tbl[6] = '{1'b0, 7'd4, 8'h00, 0, 7'd0, 40'h80_00_A5_00_11, 8'h80};

    wait_clk(4);
    rst = 1'b0;
    wait_clk(5);
    check("rst_regs1", regs1, 0);
    check("rst_regs2", regs2, 0);
    check("rst_outs", {stb1, wa1, busy1, sif1.cipo_oe, sif1.cipo}, 0);

    // table-driven frames on the default instance
    for (int i = 0; i < 7; i++) begin
      s0 = stb_cnt1;
      frame(0, {16'b0, tbl[i].rw, tbl[i].addr, tbl[i].data}, 16, 16, 0, 1'b0, rx, oe);
      check($sformatf("v%0d_strobes", i), stb_cnt1 - s0, tbl[i].stb);
      check($sformatf("v%0d_wr_addr", i), wa1, tbl[i].wa);
      check($sformatf("v%0d_regs", i), regs1, tbl[i].regs);
      check($sformatf("v%0d_idle", i), {busy1, sif1.cipo_oe, sif1.cipo}, 0);
      if (tbl[i].rw == 1'b0) begin
        check($sformatf("v%0d_rdata", i), rx[7:0], tbl[i].rd);
        check($sformatf("v%0d_oe_window", i), oe[15:0], 16'h00FF);
      end
    end

    // abort after 10 bits of a write to addr 1
    s0 = stb_cnt1;
    frame(0, {16'b0, 1'b1, 7'd1, 8'h77}, 16, 10, 0, 1'b1, rx, oe);
    check("abort_busy_mid", busy1, 1);
    wait_clk(HALF);
    ncs_drv = 1'b1;
    wait_clk(10);
    check("abort_strobes", stb_cnt1 - s0, 0);
    check("abort_regs", regs1, 40'h80_00_A5_00_11);
    check("abort_idle", {busy1, sif1.cipo_oe, sif1.cipo}, 0);
    s0 = stb_cnt1;
    frame(0, {16'b0, 1'b1, 7'd1, 8'h3C}, 16, 16, 0, 1'b0, rx, oe);
    check("after_abort_strobes", stb_cnt1 - s0, 1);
    check("after_abort_regs", regs1, 40'h80_00_A5_3C_11);
    check("after_abort_wr_addr", wa1, 1);

    // reset at bit 12 of a write with registers preloaded
    frame(0, {16'b0, 1'b1, 7'd3, 8'h99}, 16, 12, 0, 1'b1, rx, oe);
    rst = 1'b1;
    wait_clk(3);
    check("midrst_regs", regs1, 0);
    check("midrst_outs", {stb1, wa1, busy1, sif1.cipo_oe, sif1.cipo}, 0);
    rst = 1'b0;
    ncs_drv = 1'b1;
    wait_clk(2*HALF);
    s0 = stb_cnt1;
    frame(0, {16'b0, 1'b1, 7'd3, 8'h5A}, 16, 16, 0, 1'b0, rx, oe);
    check("postrst_strobes", stb_cnt1 - s0, 1);
    check("postrst_regs", regs1, 40'h00_5A_00_00_00);

    // overrun pulses then an immediate second frame
    s0 = stb_cnt1;
    frame(0, {16'b0, 1'b1, 7'd0, 8'h11}, 16, 16, 8, 1'b0, rx, oe);
    check("overrun_strobes", stb_cnt1 - s0, 1);
    check("overrun_regs", regs1, 40'h00_5A_00_00_11);
    s0 = stb_cnt1;
    frame(0, {16'b0, 1'b1, 7'd3, 8'h22}, 16, 16, 0, 1'b0, rx, oe);
    check("b2b_strobes", stb_cnt1 - s0, 1);
    check("b2b_regs", regs1, 40'h00_22_00_00_11);
    check("b2b_wr_addr", wa1, 3);

    // wide instance: ADDR_W=4, DATA_W=16, NUM_REGS=12
    s0 = stb_cnt2;
    frame(1, {11'b0, 1'b1, 4'd0, 16'h1111}, 21, 21, 8, 1'b0, rx, oe);
    check("w_overrun_strobes", stb_cnt2 - s0, 1);
    check("w_overrun_regs", regs2, 192'h1111);
    s0 = stb_cnt2;
    frame(1, {11'b0, 1'b1, 4'd11, 16'h2222}, 21, 21, 0, 1'b0, rx, oe);
    check("w_top_strobes", stb_cnt2 - s0, 1);
    check("w_top_regs", regs2, (192'h2222 << 176) | 192'h1111);
    check("w_top_wr_addr", wa2, 11);
    s0 = stb_cnt2;
    frame(1, {11'b0, 1'b1, 4'd12, 16'hFFFF}, 21, 21, 0, 1'b0, rx, oe);
    check("w_oor_strobes", stb_cnt2 - s0, 0);
    check("w_oor_regs", regs2, (192'h2222 << 176) | 192'h1111);
    check("w_oor_wr_addr", wa2, 11);
    frame(1, {11'b0, 1'b0, 4'd11, 16'h0000}, 21, 21, 0, 1'b0, rx, oe);
    check("w_rd11_data", rx[15:0], 16'h2222);
    check("w_rd11_oe_window", oe[20:0], 21'h00FFFF);
    frame(1, {11'b0, 1'b0, 4'd0, 16'h0000}, 21, 21, 0, 1'b0, rx, oe);
    check("w_rd0_data", rx[15:0], 16'h1111);
    check("w_idle", {busy2, sif2.cipo_oe, sif2.cipo}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
